// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // Index reached by stepping k places past base in a ring of n entries.
  function automatic int wrap_add(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Round-robin picker: first set request after 'last', wrapping, with 'last' itself searched last.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[wrap_add(int'(last), k, N)]) begin
        found = 1'b1;
        idx   = IW'(wrap_add(int'(last), k, N));
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO push port among NUM_REQ valid/ready producers with round-robin,
// burst-limited grants. Accepted words pass straight through to the FIFO.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 4,
  parameter int STOP_ON_AFULL = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_last_q, rr_last_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            grant_valid;
  logic            beat;
  logic            burst_done;
  logic [DATA_WIDTH-1:0] word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .last  (rr_last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign grant_valid = req_valid[grant_q];
  assign beat        = (state_q == ARB_BURST) && grant_valid && !fifo_full;
  assign burst_done  = (beat_cnt_q == BW'(MAX_BURST - 1)) ||
                       ((STOP_ON_AFULL != 0) && fifo_almost_full);

  // Outputs follow the registered grant; only the grantee ever sees ready.
  always_comb begin
    req_ready = '0;
    if (state_q == ARB_BURST) req_ready[grant_q] = !fifo_full;
  end

  assign fifo_push = beat;
  assign fifo_data = beat ? word[grant_q] : '0;
  assign grant_id  = grant_q;
  assign busy      = (state_q == ARB_BURST);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // A full FIFO with a valid grantee stalls here with the count frozen.
        if (!grant_valid) begin
          state_d   = ARB_IDLE;
          rr_last_d = grant_q;
        end else if (!fifo_full) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (burst_done) begin
            state_d   = ARB_IDLE;
            rr_last_d = grant_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_last_q  <= IW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: producer and FIFO models driven from one initial block.
module tb_fifo_push_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_push;
  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic [1:0]  grant_id;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] src_base [4];
  int         src_cnt  [4];
  int         src_idx  [4];
  logic [3:0] src_en;
  logic       full_force, afull_force;
  logic       prev_busy;
  logic       last_push, last_busy;
  logic [3:0] last_ready;
  logic [7:0] q    [$];
  int         pcyc [$];
  logic [1:0] glog [$];

  fifo_push_arbiter #(
    .DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4), .STOP_ON_AFULL(1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_push        (fifo_push),
    .fifo_data        (fifo_data),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      logic v;
      v = src_en[i] && (src_idx[i] < src_cnt[i]);
      req_valid[i] = v;
      req_data[i*8 +: 8] = v ? src_base[i] + 8'(src_idx[i]) : 8'h00;
    end
    fifo_full        = full_force || (q.size() >= 16);
    fifo_almost_full = afull_force;
  endtask

  function automatic bit pending();
    for (int i = 0; i < 4; i++)
      if (src_en[i] && (src_idx[i] < src_cnt[i])) return 1'b1;
    return 1'b0;
  endfunction

  // Sample on the falling edge, advance the producers just after the rising edge.
  task automatic cycle();
    logic [3:0] acc;
    @(negedge clk);
    last_push  = fifo_push;
    last_ready = req_ready;
    last_busy  = busy;
    if (fifo_push) begin
      q.push_back(fifo_data);
      pcyc.push_back(cyc);
    end
    acc = req_valid & req_ready;
    if (busy && !prev_busy) glog.push_back(grant_id);
    prev_busy = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) src_idx[i]++;
    cyc++;
    drive();
  endtask

  task automatic set_src(input int i, input logic [7:0] base, input int cnt);
    src_base[i] = base;
    src_cnt[i]  = cnt;
    src_idx[i]  = 0;
    src_en[i]   = 1'b1;
    drive();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    full_force  = 1'b0;
    afull_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_en[i]   = 1'b0;
      src_idx[i]  = 0;
      src_cnt[i]  = 0;
      src_base[i] = 8'h00;
    end
    q.delete();
    pcyc.delete();
    glog.delete();
    prev_busy = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int n;
    n = 0;
    while ((pending() || busy) && n < max) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    check({tag, "_timeout"}, 32'(n < max), 32'd1);
  endtask

  task automatic check_fifo(input string tag, input logic [7:0] exp [$]);
    check({tag, "_count"}, 32'(q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 32'(q[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp [$];
    int n;
    rst_n = 1'b0;
    do_reset();

    check("rst_busy",      32'(busy),      32'd0);
    check("rst_grant",     32'(grant_id),  32'd0);
    check("rst_ready",     32'(req_ready), 32'd0);
    check("rst_push",      32'(fifo_push), 32'd0);
    check("rst_data",      32'(fifo_data), 32'd0);

    // Single requester: two 4-beat bursts with one bubble between.
    set_src(1, 8'h10, 8);
    run_until_idle("t1", 60);
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    check_fifo("t1", exp);
    check("t1_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("t1_grant0", 32'(glog[0]), 32'd1);
      check("t1_grant1", 32'(glog[1]), 32'd1);
    end
    if (pcyc.size() == 8) begin
      check("t1_burst_span", 32'(pcyc[3] - pcyc[0]), 32'd3);
      check("t1_bubble",     32'(pcyc[4] - pcyc[3]), 32'd2);
    end

    // All four valid: round-robin 0,1,2,3 fills the 16-deep FIFO.
    do_reset();
    set_src(0, 8'h20, 4);
    set_src(1, 8'h30, 4);
    set_src(2, 8'h40, 4);
    set_src(3, 8'h50, 4);
    run_until_idle("t2", 80);
    exp = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
            8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h51, 8'h52, 8'h53};
    check_fifo("t2", exp);
    check("t2_grants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      check($sformatf("t2_grant%0d", i), 32'(glog[i]), 32'(i));

    // FIFO full for three cycles after beat 2.
    do_reset();
    set_src(0, 8'h60, 4);
    n = 0;
    while (q.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    check("t3_reach_beat2", 32'(n < 20), 32'd1);
    full_force = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("t3_stall%0d_push", i),  32'(last_push),  32'd0);
      check($sformatf("t3_stall%0d_ready", i), 32'(last_ready), 32'd0);
      check($sformatf("t3_stall%0d_busy", i),  32'(last_busy),  32'd1);
    end
    full_force = 1'b0;
    drive();
    run_until_idle("t3", 30);
    exp = '{8'h60, 8'h61, 8'h62, 8'h63};
    check_fifo("t3", exp);
    check("t3_grants", 32'(glog.size()), 32'd1);

    // Almost-full on r2's first beat cuts its burst short; r3 goes next.
    do_reset();
    set_src(2, 8'h70, 4);
    set_src(3, 8'h80, 4);
    n = 0;
    while (!busy && n < 10) begin
      cycle();
      n++;
    end
    check("t4_reach_burst", 32'(n < 10), 32'd1);
    afull_force = 1'b1;
    drive();
    cycle();
    afull_force = 1'b0;
    drive();
    run_until_idle("t4", 60);
    exp = '{8'h70, 8'h80, 8'h81, 8'h82, 8'h83, 8'h71, 8'h72, 8'h73};
    check_fifo("t4", exp);
    check("t4_grants", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      check("t4_grant0", 32'(glog[0]), 32'd2);
      check("t4_grant1", 32'(glog[1]), 32'd3);
      check("t4_grant2", 32'(glog[2]), 32'd2);
    end

    // Early release: r0 runs dry after two beats, r1 takes over after one IDLE.
    do_reset();
    set_src(0, 8'h90, 2);
    set_src(1, 8'hA0, 4);
    run_until_idle("t5", 40);
    exp = '{8'h90, 8'h91, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_fifo("t5", exp);
    check("t5_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("t5_grant0", 32'(glog[0]), 32'd0);
      check("t5_grant1", 32'(glog[1]), 32'd1);
    end
    if (pcyc.size() == 6)
      check("t5_release_gap", 32'(pcyc[2] - pcyc[1]), 32'd3);

    // Reset asserted on beat 2 of r2's second burst.
    do_reset();
    set_src(2, 8'hB0, 8);
    n = 0;
    while (q.size() < 5 && n < 30) begin
      cycle();
      n++;
    end
    check("t6_reach_beat", 32'(n < 30), 32'd1);
    check("t6_push_before",  32'(fifo_push), 32'd1);
    check("t6_grant_before", 32'(grant_id),  32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",  32'(busy),      32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    check("t6_rst_push",  32'(fifo_push), 32'd0);
    check("t6_rst_data",  32'(fifo_data), 32'd0);
    check("t6_rst_grant", 32'(grant_id),  32'd0);
    do_reset();
    set_src(0, 8'hD0, 4);
    set_src(1, 8'hE0, 4);
    set_src(2, 8'hF0, 4);
    set_src(3, 8'h00, 4);
    run_until_idle("t6", 80);
    check("t6_count", 32'(q.size()), 32'd16);
    if (glog.size() > 0) check("t6_first_grant", 32'(glog[0]), 32'd0);
    else check("t6_first_grant_seen", 32'(glog.size()), 32'd1);
    for (int i = 0; i < 4 && i < q.size(); i++)
      check($sformatf("t6_word%0d", i), 32'(q[i]), 32'(8'hD0 + 8'(i)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
